// File: rtl/note_sequencer_pkg.sv
// Shared types for the note sequencer: FSM states and play-mode encodings.
package note_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_e;

endpackage

// File: rtl/tempo_prescaler.sv
// Tempo prescaler: counts enabled cycles and ticks once every divisor+1 of them.
module tempo_prescaler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] divisor,
  output logic             tick
);

  logic [WIDTH-1:0] count_q;

  // Tick on the last enabled cycle of a note; combinational so the parent can
  // register the resulting index change on the same edge.
  always_comb begin
    tick = enable && (count_q == divisor);
  end

  // Counter holds while disabled so a paused note resumes its remaining count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= tick ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer top: run/stop FSM, index/direction stepping and one-hot buzzer decode.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned NOTE_BITS   = 3,
  parameter int unsigned TEMPO_WIDTH = 16
) (
  input  logic                     input_clock1_1,
  input  logic                     input_reset_2,
  input  logic                     input_start_3,
  input  logic                     input_stop_4,
  input  logic                     input_enable_5,
  input  logic [1:0]               input_mode_6,
  input  logic [TEMPO_WIDTH-1:0]   input_tempo_7,
  output logic [(1<<NOTE_BITS)-1:0] output_buzzer_8,
  output logic [NOTE_BITS-1:0]     output_index_9,
  output logic                     output_step_10,
  output logic                     output_busy_11,
  output logic                     output_done_12
);

  localparam int unsigned NOTES = 1 << NOTE_BITS;
  localparam logic [NOTE_BITS-1:0] LAST_IDX = {NOTE_BITS{1'b1}};

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [TEMPO_WIDTH-1:0] tempo_q, tempo_d;
  logic [NOTE_BITS-1:0]   index_q, index_d;
  logic                   dir_q, dir_d;  // 1 = counting down
  logic [NOTES-1:0]       buzzer_q, buzzer_d;
  logic                   step_q, step_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic presc_clear;
  logic presc_en;
  logic tick;

  // Prescaler only runs while playing; any other state (or stop) parks it at zero.
  always_comb begin
    presc_clear = (state_q != PLAY) || input_stop_4;
    presc_en    = (state_q == PLAY) && input_enable_5 && !input_stop_4;
  end

  tempo_prescaler #(
    .WIDTH(TEMPO_WIDTH)
  ) u_prescaler (
    .clk     (input_clock1_1),
    .rst     (input_reset_2),
    .clear   (presc_clear),
    .enable  (presc_en),
    .divisor (tempo_q),
    .tick    (tick)
  );

  // Next-state, index stepping and registered-output precomputation.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tempo_d = tempo_q;
    index_d = index_q;
    dir_d   = dir_q;
    step_d  = 1'b0;

    if (input_stop_4) begin
      state_d = IDLE;
      index_d = '0;
      dir_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (input_start_3) begin
            state_d = PLAY;
            mode_d  = mode_e'(input_mode_6);
            tempo_d = input_tempo_7;
            dir_d   = (mode_e'(input_mode_6) == MODE_DOWN);
            index_d = (mode_e'(input_mode_6) == MODE_DOWN) ? LAST_IDX : '0;
          end
        end
        PLAY: begin
          if (tick) begin
            step_d = 1'b1;
            unique case (mode_q)
              MODE_UP:   index_d = index_q + 1'b1;
              MODE_DOWN: index_d = index_q - 1'b1;
              MODE_PINGPONG: begin
                // Turn around at the ends without repeating the endpoint.
                if (!dir_q) begin
                  if (index_q == LAST_IDX) begin
                    index_d = index_q - 1'b1;
                    dir_d   = 1'b1;
                  end else begin
                    index_d = index_q + 1'b1;
                  end
                end else begin
                  if (index_q == '0) begin
                    index_d = index_q + 1'b1;
                    dir_d   = 1'b0;
                  end else begin
                    index_d = index_q - 1'b1;
                  end
                end
              end
              MODE_ONESHOT: begin
                if (index_q == LAST_IDX) begin
                  state_d = DONE;
                  step_d  = 1'b0;
                end else begin
                  index_d = index_q + 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d   = (state_d == PLAY);
    done_d   = (state_d == DONE);
    buzzer_d = '0;
    if ((state_d == PLAY) && input_enable_5) begin
      buzzer_d[index_d] = 1'b1;
    end
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge input_clock1_1) begin
    if (input_reset_2) begin
      state_q  <= IDLE;
      mode_q   <= MODE_UP;
      tempo_q  <= '0;
      index_q  <= '0;
      dir_q    <= 1'b0;
      buzzer_q <= '0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      tempo_q  <= tempo_d;
      index_q  <= index_d;
      dir_q    <= dir_d;
      buzzer_q <= buzzer_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign output_buzzer_8 = buzzer_q;
  assign output_index_9  = index_q;
  assign output_step_10  = step_q;
  assign output_busy_11  = busy_q;
  assign output_done_12  = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer (NOTE_BITS=3, TEMPO_WIDTH=16).
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] tempo;
  logic [7:0]  buzzer;
  logic [2:0]  index;
  logic        step;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int pp_seq [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

  always #5 clk = ~clk;

  note_sequencer #(
    .NOTE_BITS   (3),
    .TEMPO_WIDTH (16)
  ) dut (
    .input_clock1_1  (clk),
    .input_reset_2   (rst),
    .input_start_3   (start),
    .input_stop_4    (stop),
    .input_enable_5  (en),
    .input_mode_6    (mode),
    .input_tempo_7   (tempo),
    .output_buzzer_8 (buzzer),
    .output_index_9  (index),
    .output_step_10  (step),
    .output_busy_11  (busy),
    .output_done_12  (done)
  );

  // Advance one clock and sample just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] oh(input int i);
    logic [7:0] v;
    v = 8'h01 << i;
    return v;
  endfunction

  // Packs {busy, done, step, index, buzzer}.
  function automatic logic [13:0] ev(input logic b, input logic d, input logic s,
                                     input logic [2:0] i, input logic [7:0] z);
    return {b, d, s, i, z};
  endfunction

  task automatic chk(input string tag, input logic [13:0] expv);
    logic [13:0] obs;
    obs = {busy, done, step, index, buzzer};
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed {busy,done,step,idx,buz}=%h expected %h", tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; mode = 2'b00; tempo = 16'd0;
    cyc(); cyc();
    chk("reset", ev(0, 0, 0, 3'd0, 8'h00));
    rst = 1'b0;
    cyc();
    chk("idle", ev(0, 0, 0, 3'd0, 8'h00));

    // Up-loop, D=2: every note held 3 cycles, wrap 7 -> 0.
    mode = 2'b00; tempo = 16'd2; en = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("up k%0d c%0d", k, c),
            ev(1, 0, (c == 0 && k > 0), 3'(k % 8), oh(k % 8)));
        cyc();
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop up", ev(0, 0, 0, 3'd0, 8'h00));

    // Ping-pong, D=0: one note per cycle, endpoints not repeated.
    mode = 2'b10; tempo = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("pp %0d", i), ev(1, 0, (i > 0), 3'(pp_seq[i]), oh(pp_seq[i])));
      cyc();
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop pp", ev(0, 0, 0, 3'd0, 8'h00));

    // One-shot, D=1: 16 PLAY cycles, then DONE holding index 7.
    mode = 2'b11; tempo = 16'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("os c%0d", c), ev(1, 0, (c % 2 == 0 && c > 0), 3'(c / 2), oh(c / 2)));
      cyc();
    end
    chk("os done", ev(0, 1, 0, 3'd7, 8'h00));
    cyc();
    chk("os hold", ev(0, 1, 0, 3'd7, 8'h00));
    start = 1'b1; cyc(); start = 1'b0;
    chk("os replay 0", ev(1, 0, 0, 3'd0, 8'h01));
    cyc();
    chk("os replay 1", ev(1, 0, 0, 3'd0, 8'h01));
    cyc();
    chk("os replay 2", ev(1, 0, 1, 3'd1, 8'h02));
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop os", ev(0, 0, 0, 3'd0, 8'h00));

    // Down-loop, D=3, pause for 5 cycles after the third cycle of note 7.
    mode = 2'b01; tempo = 16'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("dn start", ev(1, 0, 0, 3'd7, 8'h80));
    cyc(); cyc();
    chk("dn pre-pause", ev(1, 0, 0, 3'd7, 8'h80));
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("pause %0d", i), ev(1, 0, 0, 3'd7, 8'h00));
    end
    en = 1'b1;
    cyc();
    chk("dn resume", ev(1, 0, 0, 3'd7, 8'h80));
    cyc();
    chk("dn adv 6", ev(1, 0, 1, 3'd6, 8'h40));
    cyc(); cyc(); cyc();
    chk("dn hold 6", ev(1, 0, 0, 3'd6, 8'h40));
    cyc();
    chk("dn adv 5", ev(1, 0, 1, 3'd5, 8'h20));

    // Mid-run mode/tempo change and re-start are ignored.
    mode = 2'b00; tempo = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("ignore start", ev(1, 0, 0, 3'd5, 8'h20));
    cyc(); cyc();
    chk("old tempo", ev(1, 0, 0, 3'd5, 8'h20));
    cyc();
    chk("old dir", ev(1, 0, 1, 3'd4, 8'h10));
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop dn", ev(0, 0, 0, 3'd0, 8'h00));

    // start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    cyc();
    chk("start+stop 0", ev(0, 0, 0, 3'd0, 8'h00));
    cyc();
    chk("start+stop 1", ev(0, 0, 0, 3'd0, 8'h00));
    start = 1'b0; stop = 1'b0;

    // Stop in PLAY at index 5.
    mode = 2'b00; tempo = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("at 5", ev(1, 0, 1, 3'd5, 8'h20));
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop at 5", ev(0, 0, 0, 3'd0, 8'h00));

    // Reset mid-run.
    mode = 2'b10; tempo = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    chk("pp pre-reset", ev(1, 0, 1, 3'd3, 8'h08));
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("reset mid", ev(0, 0, 0, 3'd0, 8'h00));
    cyc();
    chk("post reset idle", ev(0, 0, 0, 3'd0, 8'h00));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
